// File: rtl/piso_shifter.sv
// piso_shifter: parallel-in / serial-out shifter with a load handshake.
//
// A word on D is captured when LOAD=1 and READY=1. It then appears on Q, one
// bit per cycle for WIDTH cycles, starting in the cycle after the load edge.
// The order is MSB first when MSB_FIRST=1 and LSB first otherwise.
// A new word may be loaded on the edge that ends the final bit. This gives
// gap-free back-to-back streaming.
//
// Parameters:
//   WIDTH     - bits per parallel word (2..32)
//   MSB_FIRST - 1: bit WIDTH-1 goes first, 0: bit 0 goes first
// Ports:
//   CLK   in   clock, rising edge
//   RST_N in   asynchronous active-low reset
//   D     in   parallel word, sampled only on an accepted load edge
//   LOAD  in   load request, qualified by READY
//   READY out  LOAD is accepted this cycle
//   Q     out  serial data bit (0 when idle)
//   invQ  out  complement of Q
//   VALID out  Q carries a payload bit
//   DONE  out  final bit of the current word is on Q
module piso_shifter #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD,
  output logic             READY,
  output logic             Q,
  output logic             invQ,
  output logic             VALID,
  output logic             DONE
);

  localparam int unsigned     CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh;
  logic             last;
  logic             load_acc;
  logic             head;

  // Every output is decoded from registered state only. LOAD affects only
  // next-state, never the current outputs.
  always_comb begin
    last     = 1'b0;
    READY    = 1'b0;
    load_acc = 1'b0;
    state_nx = state;
    last     = (state == SHIFT) && (cnt == LAST);
    READY    = (state == IDLE) || last;
    load_acc = LOAD && READY;
    case (state)
      IDLE:    if (load_acc) state_nx = SHIFT;
      SHIFT:   if (last)     state_nx = load_acc ? SHIFT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
      sh  <= '0;
    end else if (load_acc) begin
      cnt <= '0;
      sh  <= D;
    end else if (state == SHIFT) begin
      cnt <= last ? '0 : cnt + 1'b1;
      sh  <= MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
    end
  end

  always_comb begin
    head  = MSB_FIRST ? sh[WIDTH-1] : sh[0];
    VALID = (state == SHIFT);
    Q     = VALID & head;
    invQ  = ~Q;
    DONE  = last;
  end

endmodule

// File: tb/tb_piso_shifter.sv
// Directed bench for piso_shifter.
// u0 uses the defaults (WIDTH=8, MSB first). u1 is configured LSB first.
module tb_piso_shifter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d0, d1;
  logic       load0, load1;
  logic       ready0, q0, iq0, valid0, done0;
  logic       ready1, q1, iq1, valid1, done1;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  piso_shifter #(.WIDTH(8), .MSB_FIRST(1'b1)) u0 (
    .CLK(clk), .RST_N(rst_n), .D(d0), .LOAD(load0), .READY(ready0),
    .Q(q0), .invQ(iq0), .VALID(valid0), .DONE(done0)
  );

  piso_shifter #(.WIDTH(8), .MSB_FIRST(1'b0)) u1 (
    .CLK(clk), .RST_N(rst_n), .D(d1), .LOAD(load1), .READY(ready1),
    .Q(q1), .invQ(iq1), .VALID(valid1), .DONE(done1)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
  endtask

  task automatic chk0(input string tag, input logic q, input logic v,
                      input logic dn, input logic rdy);
    chk({tag, ".Q"},     q0,     q);
    chk({tag, ".invQ"},  iq0,    ~q);
    chk({tag, ".VALID"}, valid0, v);
    chk({tag, ".DONE"},  done0,  dn);
    chk({tag, ".READY"}, ready0, rdy);
  endtask

  task automatic chk1(input string tag, input logic q, input logic v,
                      input logic dn, input logic rdy);
    chk({tag, ".Q"},     q1,     q);
    chk({tag, ".invQ"},  iq1,    ~q);
    chk({tag, ".VALID"}, valid1, v);
    chk({tag, ".DONE"},  done1,  dn);
    chk({tag, ".READY"}, ready1, rdy);
  endtask

  // Inputs change and outputs are sampled 2 time units after each rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [7:0]  w;
    logic [15:0] w16;

    rst_n = 1'b0;
    d0 = 8'h00; d1 = 8'h00; load0 = 1'b0; load1 = 1'b0;

    // Reset is in force before any clock edge.
    #1;
    chk0("rst", 1'b0, 1'b0, 1'b0, 1'b1);
    chk1("rst1", 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk0("rst_edge", 1'b0, 1'b0, 1'b0, 1'b1);

    // Release reset, then stay idle for 5 cycles.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk0($sformatf("idle%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // A5, MSB first. This load is offered at the end of the idle period.
    w = 8'hA5;
    d0 = w; load0 = 1'b1;
    step();
    load0 = 1'b0; d0 = 8'h3C;  // changing D mid-word must not matter
    for (int i = 0; i < 8; i++) begin
      chk0($sformatf("a5_b%0d", i), w[7-i], 1'b1, i == 7, i == 7);
      if (i < 7) step();
    end
    step();
    chk0("a5_end", 1'b0, 1'b0, 1'b0, 1'b1);

    // F0 then 0F back-to-back: 16 contiguous bits, DONE at bits 8 and 16.
    w16 = 16'hF00F;
    d0 = 8'hF0; load0 = 1'b1;
    step();
    load0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk0($sformatf("b2b_b%0d", i), w16[15-i], 1'b1, (i == 7) || (i == 15),
           (i == 7) || (i == 15));
      load0 = (i == 7);
      d0    = (i == 7) ? 8'h0F : 8'h55;
      step();
    end
    load0 = 1'b0;
    chk0("b2b_end", 1'b0, 1'b0, 1'b0, 1'b1);

    // Word 00: LOAD=1 with D=FF during cycles 2-7 is ignored.
    d0 = 8'h00; load0 = 1'b1;
    step();
    load0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk0($sformatf("ign_b%0d", i), 1'b0, 1'b1, i == 7, i == 7);
      load0 = (i >= 0) && (i < 6);
      d0    = 8'hFF;
      step();
    end
    load0 = 1'b0;
    chk0("ign_end", 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk0("ign_idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // LSB first, word 01: 1 then seven 0s.
    d1 = 8'h01; load1 = 1'b1;
    step();
    load1 = 1'b0; d1 = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      chk1($sformatf("lsb_b%0d", i), i == 0, 1'b1, i == 7, i == 7);
      step();
    end
    chk1("lsb_end", 1'b0, 1'b0, 1'b0, 1'b1);

    // Word FF, asynchronous reset in the middle of bit 4.
    d0 = 8'hFF; load0 = 1'b1;
    step();
    load0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk0($sformatf("ab_b%0d", i), 1'b1, 1'b1, 1'b0, 1'b0);
      if (i < 3) step();
    end
    #1 rst_n = 1'b0;
    #1;
    chk0("ab_rst", 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk0("ab_hold", 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk0($sformatf("ab_post%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // A LOAD on the first edge after reset release is accepted.
    @(negedge clk);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    d0 = 8'h80; load0 = 1'b1;
    step();
    load0 = 1'b0;
    chk0("first_edge", 1'b1, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piso_shifter.md
PISO_SHIFTER -- requirements
Module: piso_shifter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of bits per parallel word (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1; 1 means bit WIDTH-1 is sent first, 0 means bit 0 is sent first.
REQ-003 The block SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RST_N  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port D  input  WIDTH  parallel word to serialize.
REQ-006 The block SHALL have port LOAD  input  1  load request, qualified by READY.
REQ-007 The block SHALL have port READY  output  1  block accepts LOAD this cycle.
REQ-008 The block SHALL have port Q  output  1  serial data bit.
REQ-009 The block SHALL have port invQ  output  1  complement of Q.
REQ-010 The block SHALL have port VALID  output  1  Q carries a payload bit this cycle.
REQ-011 The block SHALL have port DONE  output  1  one-cycle pulse marking the last bit of a word.

Function
REQ-012 The block SHALL implement a two-state FSM, IDLE and SHIFT, plus a WIDTH-bit shift register and a bit counter of ceil(log2(WIDTH)) bits.
REQ-013 READY SHALL be 1 in IDLE, and 1 in SHIFT only when the counter equals WIDTH-1; it SHALL be 0 otherwise.
REQ-014 A load SHALL occur on a rising edge where LOAD=1 and READY=1: D is captured, the counter is cleared and the state becomes SHIFT.
REQ-015 When LOAD=1 and READY=0, LOAD SHALL be ignored, with no capture and no state change.
REQ-016 Latency: the first bit SHALL appear on Q with VALID=1 in the cycle immediately after the load edge.
REQ-017 Bits SHALL be presented one per cycle for exactly WIDTH consecutive cycles, in the order set by MSB_FIRST.
REQ-018 DONE SHALL be 1 only in the cycle presenting bit number WIDTH-1 (the final bit).
REQ-019 If no load occurs on the edge ending the final-bit cycle, the state SHALL return to IDLE.
REQ-020 Back-to-back: a load on the edge ending the final-bit cycle SHALL start the next word with no gap cycle, keeping VALID continuously 1.
REQ-021 In IDLE, Q SHALL be 0, VALID 0 and DONE 0.
REQ-022 invQ SHALL equal the inverse of Q in every cycle, including during reset.
REQ-023 D SHALL be sampled only on the load edge; changes to D at any other time SHALL have no effect on the word in flight.
REQ-024 Q, VALID and DONE SHALL be driven from registers or decoded from registered state only, with no combinational path from D or LOAD.

Reset
REQ-025 While RST_N=0, the block SHALL immediately force state IDLE, counter 0, shift register 0, Q=0, invQ=1, VALID=0, DONE=0 and READY=1, independent of CLK.
REQ-026 Reset asserted mid-word SHALL abort the word: no DONE is issued and the remaining bits are discarded.
REQ-027 A LOAD presented on the first rising edge after RST_N rises SHALL be accepted.

Verification
REQ-028 The bench SHALL cover: reset, then idle for 5 cycles -> Q=0, invQ=1, VALID=0, DONE=0, READY=1 throughout.
REQ-029 The bench SHALL cover: WIDTH=8, MSB_FIRST=1, load D=8'hA5 -> over the next 8 cycles Q=1,0,1,0,0,1,0,1 with VALID=1, DONE=1 only on the 8th cycle, and READY=1 only on the 8th cycle.
REQ-030 The bench SHALL cover: MSB_FIRST=0, load D=8'h01 -> Q=1 in cycle 1, then 0 for cycles 2-8.
REQ-031 The bench SHALL cover: load 8'hF0, then hold LOAD=1 with D=8'h0F during the 8th cycle -> 16 contiguous VALID cycles carrying 1111000000001111, and exactly two DONE pulses, at cycles 8 and 16.
REQ-032 The bench SHALL cover: LOAD=1 with D=8'hFF during cycles 2-7 of a word carrying 8'h00 -> the input is ignored, the word still emits 8 zeros, and state returns to IDLE after DONE.
REQ-033 The bench SHALL cover: load 8'hFF, then drop RST_N asynchronously mid-cycle 4 -> Q=0, invQ=1 and VALID=0 immediately, with no DONE.
